// File: rtl/sram_access_ctrl_pkg.sv
// Purpose: shared types and defaults for the SRAM access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int TIMER_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_WL   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_e;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Purpose: request handshakes plus row-decoder drive bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: readies come from the controller, valids/addresses from requesters.
interface sram_access_ctrl_if
    import sram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              rd0_valid;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_ready;
    logic              rd1_valid;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_ready;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ready;
    logic [ADDR_W-1:0] address_1;
    logic [ADDR_W-1:0] address_2;
    logic [1:0]        read_enable;
    logic              write_enable;
    logic              precharge_en;
    logic              sense_en;
    logic              rd0_done;
    logic              rd1_done;
    logic              wr_done;

    // Requester side
    modport master (
        output rd0_valid, rd0_addr, rd1_valid, rd1_addr, wr_valid, wr_addr,
        input  rd0_ready, rd1_ready, wr_ready,
        input  address_1, address_2, read_enable, write_enable,
        input  precharge_en, sense_en, rd0_done, rd1_done, wr_done
    );

    // Controller side
    modport slave (
        input  rd0_valid, rd0_addr, rd1_valid, rd1_addr, wr_valid, wr_addr,
        output rd0_ready, rd1_ready, wr_ready,
        output address_1, address_2, read_enable, write_enable,
        output precharge_en, sense_en, rd0_done, rd1_done, wr_done
    );
endinterface

// File: rtl/sram_access_ctrl_phase_timer.sv
// Purpose: loadable 4-bit down-counter timing the precharge and wordline phases.
// Latency: load takes effect next cycle; zero_o reflects the current count.
// Backpressure: none; decrements only when dec_i is set, saturates at zero.
module phase_timer
    import sram_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; hold at zero so a stray dec cannot wrap
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Purpose: arbitrates 2 read ports and 1 write port, sequences precharge/wordline/sense.
// Latency: done pulses 1+PRE_CYCLES+WL_CYCLES cycles after the accept cycle.
// Backpressure: readies only assert in IDLE; one access per 2+PRE_CYCLES+WL_CYCLES cycles.
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PRE_CYCLES = 2,
    parameter int WL_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_access_ctrl_if.slave bus
);

    // Timer counts down to zero, so it is loaded with length-1
    localparam logic [TIMER_W-1:0] PRE_LOAD = TIMER_W'(PRE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WL_LOAD  = TIMER_W'(WL_CYCLES - 1);

    state_e            state_q, state_d;
    req_e              req_q, req_d;
    logic              rd0g_q, rd0g_d;
    logic              rd1g_q, rd1g_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic              prio_wr_q, prio_wr_d;   // 0: reads win a contended grant
    logic              contend_q, contend_d;   // current access was contended

    logic               any_rd, any_wr, grant_rd, grant_wr;
    logic               t_load, t_dec, t_zero;
    logic [TIMER_W-1:0] t_load_val;

    assign any_rd   = bus.rd0_valid | bus.rd1_valid;
    assign any_wr   = bus.wr_valid;
    // Both read ports ride on one read grant; the write never shares an access
    assign grant_rd = (state_q == ST_IDLE) && any_rd && (!any_wr || !prio_wr_q);
    assign grant_wr = (state_q == ST_IDLE) && any_wr && !grant_rd;

    assign bus.rd0_ready = grant_rd && bus.rd0_valid;
    assign bus.rd1_ready = grant_rd && bus.rd1_valid;
    assign bus.wr_ready  = grant_wr;

    phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .dec_i      (t_dec),
        .load_val_i (t_load_val),
        .zero_o     (t_zero)
    );

    // Next-state logic and phase timer control
    always_comb begin
        state_d    = state_q;
        t_load     = 1'b0;
        t_dec      = 1'b0;
        t_load_val = PRE_LOAD;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d = ST_PRE;
                    t_load  = 1'b1;
                end
            end
            ST_PRE: begin
                if (t_zero) begin
                    state_d    = ST_WL;
                    t_load     = 1'b1;
                    t_load_val = WL_LOAD;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_WL: begin
                if (t_zero) begin
                    state_d = ST_FIN;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the granted request; flip priority once a contended access finishes
    always_comb begin
        req_d     = req_q;
        rd0g_d    = rd0g_q;
        rd1g_d    = rd1g_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        prio_wr_d = prio_wr_q;
        contend_d = contend_q;
        if (grant_wr) begin
            req_d     = REQ_WR;
            rd0g_d    = 1'b0;
            rd1g_d    = 1'b0;
            addr1_d   = bus.wr_addr;
            contend_d = any_rd;
        end else if (grant_rd) begin
            req_d     = REQ_RD;
            rd0g_d    = bus.rd0_valid;
            rd1g_d    = bus.rd1_valid;
            contend_d = any_wr;
            // An ungranted port leaves its decoder address untouched
            if (bus.rd0_valid) addr1_d = bus.rd0_addr;
            if (bus.rd1_valid) addr2_d = bus.rd1_addr;
        end
        if ((state_q == ST_FIN) && contend_q) begin
            prio_wr_d = !prio_wr_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= REQ_RD;
            rd0g_q    <= 1'b0;
            rd1g_q    <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            prio_wr_q <= 1'b0;
            contend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rd0g_q    <= rd0g_d;
            rd1g_q    <= rd1g_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            prio_wr_q <= prio_wr_d;
            contend_q <= contend_d;
        end
    end

    // Phase outputs decode straight from state so reset clears them at once
    assign bus.address_1    = addr1_q;
    assign bus.address_2    = addr2_q;
    assign bus.precharge_en = (state_q == ST_PRE);
    assign bus.read_enable  = ((state_q == ST_WL) && (req_q == REQ_RD)) ? {rd1g_q, rd0g_q} : 2'b00;
    assign bus.write_enable = (state_q == ST_WL) && (req_q == REQ_WR);
    assign bus.sense_en     = (state_q == ST_FIN) && (req_q == REQ_RD);
    assign bus.rd0_done     = (state_q == ST_FIN) && (req_q == REQ_RD) && rd0g_q;
    assign bus.rd1_done     = (state_q == ST_FIN) && (req_q == REQ_RD) && rd1g_q;
    assign bus.wr_done      = (state_q == ST_FIN) && (req_q == REQ_WR);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Purpose: self-checking bench for sram_access_ctrl at default and swept phase lengths.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_access_ctrl;
    import sram_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_access_ctrl_if #(.ADDR_W(7)) bus1();
    sram_access_ctrl_if #(.ADDR_W(7)) bus2();

    sram_access_ctrl #(.ADDR_W(7), .PRE_CYCLES(2), .WL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    sram_access_ctrl #(.ADDR_W(7), .PRE_CYCLES(3), .WL_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rd0_v; logic [6:0] rd0_a;
        logic       rd1_v; logic [6:0] rd1_a;
        logic       wr_v;  logic [6:0] wr_a;
        logic [2:0] rdy;   // {wr, rd1, rd0}
        logic       pre;
        logic [1:0] re;
        logic       we;
        logic       sense;
        logic [2:0] done;  // {wr, rd1, rd0}
        logic [6:0] a1;
        logic [6:0] a2;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] cur_a1 = 7'h00;
    logic [6:0] cur_a2 = 7'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Five table rows for one default-length access: IDLE(accept), PRE, PRE, WL, FIN
    task automatic push_access(input logic rd0v, input logic [6:0] rd0a,
                               input logic rd1v, input logic [6:0] rd1a,
                               input logic wrv,  input logic [6:0] wra,
                               input logic hold, input logic is_wr,
                               input logic g0,   input logic g1);
        vec_t v;
        for (int c = 0; c < 5; c++) begin
            v.rd0_v = (c == 0 || hold) ? rd0v : 1'b0;
            v.rd1_v = (c == 0 || hold) ? rd1v : 1'b0;
            v.wr_v  = (c == 0 || hold) ? wrv  : 1'b0;
            v.rd0_a = rd0a; v.rd1_a = rd1a; v.wr_a = wra;
            v.rdy   = (c == 0) ? {is_wr, g1 & ~is_wr, g0 & ~is_wr} : 3'b000;
            v.pre   = (c == 1 || c == 2);
            v.re    = (c == 3 && !is_wr) ? {g1, g0} : 2'b00;
            v.we    = (c == 3 && is_wr);
            v.sense = (c == 4 && !is_wr);
            v.done  = (c == 4) ? {is_wr, g1 & ~is_wr, g0 & ~is_wr} : 3'b000;
            v.a1    = cur_a1;
            v.a2    = cur_a2;
            vecs.push_back(v);
            if (c == 0) begin
                if (is_wr) cur_a1 = wra;
                else begin
                    if (g0) cur_a1 = rd0a;
                    if (g1) cur_a2 = rd1a;
                end
            end
        end
    endtask

    function automatic logic [24:0] pack_out(input logic [2:0] rdy, input logic pre,
            input logic [1:0] re, input logic we, input logic se, input logic [2:0] dn,
            input logic [6:0] a1, input logic [6:0] a2);
        return {rdy, pre, re, we, se, dn, a1, a2};
    endfunction

    function automatic logic [24:0] bus1_out();
        return pack_out({bus1.wr_ready, bus1.rd1_ready, bus1.rd0_ready}, bus1.precharge_en,
                        bus1.read_enable, bus1.write_enable, bus1.sense_en,
                        {bus1.wr_done, bus1.rd1_done, bus1.rd0_done}, bus1.address_1, bus1.address_2);
    endfunction

    function automatic logic [24:0] bus2_out();
        return pack_out({bus2.wr_ready, bus2.rd1_ready, bus2.rd0_ready}, bus2.precharge_en,
                        bus2.read_enable, bus2.write_enable, bus2.sense_en,
                        {bus2.wr_done, bus2.rd1_done, bus2.rd0_done}, bus2.address_1, bus2.address_2);
    endfunction

    // Enables never overlap each other nor precharge
    function automatic logic inv_bad(input logic [1:0] re, input logic we, input logic pre);
        return ((re != 2'b00) && we) || (((re != 2'b00) || we) && pre);
    endfunction

    always @(negedge clk) begin
        checks++;
        if (inv_bad(bus1.read_enable, bus1.write_enable, bus1.precharge_en)) begin
            errors++;
            $display("FAIL invariant dut1: re=%b we=%b pre=%b", bus1.read_enable, bus1.write_enable, bus1.precharge_en);
        end
        checks++;
        if (inv_bad(bus2.read_enable, bus2.write_enable, bus2.precharge_en)) begin
            errors++;
            $display("FAIL invariant dut2: re=%b we=%b pre=%b", bus2.read_enable, bus2.write_enable, bus2.precharge_en);
        end
    end

    task automatic set_rd0(input int which, input logic v, input logic [6:0] a);
        if (which == 0) begin bus1.rd0_valid = v; bus1.rd0_addr = a; end
        else            begin bus2.rd0_valid = v; bus2.rd0_addr = a; end
    endtask

    // Single rd0 access, measuring done latency and phase lengths from the accept cycle
    task automatic rd0_access(input int which, input logic [6:0] addr,
                              input int exp_lat, input int exp_pre, input int exp_wl);
        int   lat, npre, nwl;
        logic got_done;
        logic [6:0] a1_seen;
        lat = 0; npre = 0; nwl = 0; got_done = 1'b0; a1_seen = 7'h00;
        @(negedge clk);
        set_rd0(which, 1'b1, addr);
        #1;
        check("accept_ready", (which == 0) ? bus1.rd0_ready : bus2.rd0_ready, 1);
        for (int n = 1; n <= 20 && !got_done; n++) begin
            @(negedge clk);
            if (n == 1) set_rd0(which, 1'b0, 7'h00);
            #1;
            if ((which == 0) ? bus1.precharge_en : bus2.precharge_en) npre++;
            if (((which == 0) ? bus1.read_enable : bus2.read_enable) != 2'b00) begin
                nwl++;
                a1_seen = (which == 0) ? bus1.address_1 : bus2.address_1;
            end
            if ((which == 0) ? bus1.rd0_done : bus2.rd0_done) begin
                lat = n;
                got_done = 1'b1;
            end
        end
        check("done_latency", lat, exp_lat);
        check("pre_cycles", npre, exp_pre);
        check("wl_cycles", nwl, exp_wl);
        check("wl_address_1", a1_seen, addr);
    endtask

    initial begin
        logic [24:0] act, exp;
        rst_n = 1'b0;
        bus1.rd0_valid = 0; bus1.rd0_addr = 0; bus1.rd1_valid = 0; bus1.rd1_addr = 0;
        bus1.wr_valid  = 0; bus1.wr_addr  = 0;
        bus2.rd0_valid = 0; bus2.rd0_addr = 0; bus2.rd1_valid = 0; bus2.rd1_addr = 0;
        bus2.wr_valid  = 0; bus2.wr_addr  = 0;

        // Lone reads, lone write, single port rd1, then rd0/write contention x4 (RD,WR,RD,WR)
        push_access(1, 7'h3C, 1, 7'h4F, 0, 7'h00, 0, 0, 1, 1);
        push_access(0, 7'h00, 0, 7'h00, 1, 7'h3C, 0, 1, 0, 0);
        push_access(0, 7'h00, 1, 7'h11, 0, 7'h00, 0, 0, 0, 1);
        push_access(1, 7'h01, 0, 7'h00, 1, 7'h02, 1, 0, 1, 0);
        push_access(1, 7'h01, 0, 7'h00, 1, 7'h02, 1, 1, 0, 0);
        push_access(1, 7'h01, 0, 7'h00, 1, 7'h02, 1, 0, 1, 0);
        push_access(1, 7'h01, 0, 7'h00, 1, 7'h02, 1, 1, 0, 0);

        #1;
        check("reset_dut1", bus1_out(), 0);
        check("reset_dut2", bus2_out(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus1.rd0_valid = vecs[i].rd0_v; bus1.rd0_addr = vecs[i].rd0_a;
            bus1.rd1_valid = vecs[i].rd1_v; bus1.rd1_addr = vecs[i].rd1_a;
            bus1.wr_valid  = vecs[i].wr_v;  bus1.wr_addr  = vecs[i].wr_a;
            #1;
            act = bus1_out();
            exp = pack_out(vecs[i].rdy, vecs[i].pre, vecs[i].re, vecs[i].we, vecs[i].sense,
                           vecs[i].done, vecs[i].a1, vecs[i].a2);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got rdy=%b pre=%b re=%b we=%b se=%b done=%b a1=%h a2=%h want rdy=%b pre=%b re=%b we=%b se=%b done=%b a1=%h a2=%h",
                         i, act[24:22], act[21], act[20:19], act[18], act[17], act[16:14], act[13:7], act[6:0],
                         exp[24:22], exp[21], exp[20:19], exp[18], exp[17], exp[16:14], exp[13:7], exp[6:0]);
            end
        end
        bus1.rd0_valid = 0; bus1.rd1_valid = 0; bus1.wr_valid = 0;

        // Reset during the wordline phase of a write
        @(negedge clk);
        bus1.wr_valid = 1; bus1.wr_addr = 7'h7A;
        #1;
        check("midrst_accept", bus1.wr_ready, 1);
        @(negedge clk);
        bus1.wr_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_wl_we", {bus1.write_enable, bus1.address_1}, {1'b1, 7'h7A});
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_drop", {bus1.read_enable, bus1.write_enable, bus1.precharge_en, bus1.sense_en}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            #1;
            check("midrst_no_done", {bus1.wr_done, bus1.rd1_done, bus1.rd0_done}, 0);
        end
        rd0_access(0, 7'h05, 4, 2, 1);

        // Longer phases on the swept instance
        rd0_access(1, 7'h22, 6, 3, 2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Initiator-side sequencer for the 128-row 2R1W bitcell array; drives the row decoder's `address_1`, `address_2`, `read_enable[1:0]` and `write_enable` inputs.
- Accepts read requests on two ports and write requests on one port, each through a valid/ready handshake.
- Arbitrates between reads and writes, then runs each access through precharge, wordline and sense/write phases.
- Returns a one-cycle done pulse per completed request.

Parameters:
- `ADDR_W`, 7, row address width (128 rows).
- `PRE_CYCLES`, 2, precharge phase length in cycles, legal range 1..15.
- `WL_CYCLES`, 1, wordline-active phase length in cycles, legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd0_valid`  in  1  read port 0 request.
- `rd0_addr`  in  ADDR_W  read port 0 row.
- `rd0_ready`  out  1  read port 0 accepted this cycle.
- `rd1_valid`  in  1  read port 1 request.
- `rd1_addr`  in  ADDR_W  read port 1 row.
- `rd1_ready`  out  1  read port 1 accepted this cycle.
- `wr_valid`  in  1  write request.
- `wr_addr`  in  ADDR_W  write row.
- `wr_ready`  out  1  write accepted this cycle.
- `address_1`  out  ADDR_W  decoder address 1; carries the read port 0 row or the write row.
- `address_2`  out  ADDR_W  decoder address 2; carries the read port 1 row.
- `read_enable`  out  2  bit0 enables read wordline 1, bit1 enables read wordline 2.
- `write_enable`  out  1  enables the write wordline, decoded from `address_1`.
- `precharge_en`  out  1  bitline precharge.
- `sense_en`  out  1  sense amplifier fire.
- `rd0_done`, `rd1_done`, `wr_done`  out  1 each  one-cycle completion pulses.

Behaviour:
- **Reset.** All outputs are 0, addresses are 0, the FSM is in IDLE, and the priority flag selects reads.
- **FSM states:** IDLE, PRE, WL, FIN.
- **IDLE.** Ready signals are combinational in IDLE only:
  - If any valid is set, the grant is issued, the accepted addresses and request type are latched, and the FSM moves to PRE.
  - If no valid is set, the FSM stays in IDLE.
- **Grant rule:**
  - A read grant accepts both `rd0_valid` and `rd1_valid` together, so both reads share one access. Their addresses may be equal.
  - Reads and the write never share an access.
  - When reads and the write are both pending, the priority flag decides. The flag toggles after every access that had contention, so reads and writes alternate under contention.
  - With no contention, the lone requester wins and the flag is unchanged.
- **PRE.**
  - `precharge_en`=1 for exactly PRE_CYCLES cycles, then the FSM moves to WL.
  - Addresses are already driven on the latched values.
  - All enables are 0.
- **WL.**
  - `precharge_en`=0.
  - Read access: `read_enable[0]`=granted rd0 and `read_enable[1]`=granted rd1.
  - Write access: `write_enable`=1.
  - Held for WL_CYCLES cycles, then the FSM moves to FIN.
- **FIN (1 cycle).**
  - Enables are 0.
  - Read access: `sense_en`=1.
  - The done pulses for the granted requests fire.
  - The FSM returns to IDLE.
- **Access latency.** An accepted request completes with done exactly 1+PRE_CYCLES+WL_CYCLES cycles after the accept edge, which is 4 cycles at defaults.
- **Back-to-back requests.** The next accept happens no earlier than the IDLE cycle after FIN, so throughput is one access per 2+PRE_CYCLES+WL_CYCLES cycles.
- **Held addresses.** `address_1` and `address_2` hold their last latched values in IDLE, which keeps the decoder inputs quiet.
- **Request stability.** Requesters hold valid and addr until ready; a change of addr before ready is legal and has no effect.
- **Invariant.** `read_enable` and `write_enable` are never both non-zero, and no enable is ever high while `precharge_en` is high.
- **Reset mid-access.** All enables and `precharge_en` drop immediately (asynchronously), no done pulse fires, and the FSM restarts in IDLE after `rst_n` deasserts.

Decomposition:
- **Shared package:** FSM state enum, `ADDR_W` default, request-type enum (RD, WR).
- **Sub-module `phase_timer`:** loadable 4-bit down-counter with a `zero` flag, reused for the PRE and WL phases.

Test Plan:
- **Lone reads:** `rd0_valid` addr=0x3C and `rd1_valid` addr=0x4F asserted together.
  - Both readies are high in the same cycle.
  - `precharge_en` is high for 2 cycles, then `read_enable`=2'b11 for 1 cycle with `address_1`=0x3C and `address_2`=0x4F.
  - `sense_en` and both done pulses fire at accept+4.
- **Lone write:** `wr_valid` addr=0x3C.
  - `write_enable`=1 with `address_1`=0x3C.
  - `read_enable`=0 throughout; `sense_en` stays 0; `wr_done` fires at accept+4.
- **Contention:** rd0 (addr=0x01) and write (addr=0x02) held valid continuously for 4 accesses.
  - Grant order is RD, WR, RD, WR.
  - Each access is 5 cycles apart.
- **Single port:** only `rd1_valid` asserted.
  - `read_enable`=2'b10 for the access; `rd0_done` stays 0.
- **Reset mid-access:** `rst_n` pulled low during WL.
  - `read_enable` and `write_enable` are 0 in the same cycle; no done pulse.
  - After release, a new request completes normally.
- **Parameter sweep:** PRE_CYCLES=3, WL_CYCLES=2.
  - Done arrives at accept+6.
  - The enable-versus-precharge exclusivity invariant holds every cycle.
